// File: rtl/seg7_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder_if
// Purpose  : Scanned 7-segment display tap and decoded-frame result bundle.
// Revision : 1.0
// ============================================================================
interface seg7_scan_decoder_if;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] value;
    logic [3:0]  valid;
    logic [3:0]  blank;
    logic        frame_done;
    logic        bad_pat;
    logic        an_err;
    logic        stale;

    modport master (
        output seg, an,
        input  value, valid, blank, frame_done, bad_pat, an_err, stale
    );

    modport slave (
        input  seg, an,
        output value, valid, blank, frame_done, bad_pat, an_err, stale
    );
endinterface
`default_nettype wire

// File: rtl/seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_decoder
// Purpose  : Recovers a 4-digit hex frame by sniffing a multiplexed display.
// Revision : 1.0
// ============================================================================
module seg7_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 1000000
) (
    input wire                 clk,
    input wire                 rst,
    seg7_scan_decoder_if.slave bus
);

    localparam logic [7:0]  c_stable   = 8'(STABLE_CYCLES);
    localparam logic [23:0] c_timeout  = 24'(TIMEOUT);

    localparam logic [1:0]  c_st_idle  = 2'd0;
    localparam logic [1:0]  c_st_track = 2'd1;
    localparam logic [1:0]  c_st_held  = 2'd2;

    logic [6:0]  r_seg_s1, r_seg_s2, r_seg_q;
    logic [3:0]  r_an_s1, r_an_s2, r_an_q;
    logic [1:0]  r_state, w_state_nxt;
    logic [7:0]  r_cnt, w_cnt_nxt, w_cnt_new;
    logic        w_capture;
    logic        w_onehot, w_prev_onehot, w_illegal, w_prev_illegal, w_same;
    logic        w_dec_hit, w_dec_blank;
    logic [3:0]  w_dec_nib;
    logic [3:0]  w_cap_bits;
    logic [3:0]  r_mask;
    logic [15:0] r_sh_val;
    logic [3:0]  r_sh_valid, r_sh_blank;
    logic [15:0] r_value;
    logic [3:0]  r_valid, r_blank;
    logic        r_frame_done, r_bad_pat, r_an_err;
    logic [23:0] r_idle;

    function automatic logic is_onehot_low(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) || (a == 4'b1011) || (a == 4'b0111);
    endfunction

    // Two-flop synchroniser plus one extra stage holding last cycle's value
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_seg_s1 <= 7'b1111111;
            r_seg_s2 <= 7'b1111111;
            r_seg_q  <= 7'b1111111;
            r_an_s1  <= 4'b1111;
            r_an_s2  <= 4'b1111;
            r_an_q   <= 4'b1111;
        end else begin
            r_seg_s1 <= bus.seg;
            r_seg_s2 <= r_seg_s1;
            r_seg_q  <= r_seg_s2;
            r_an_s1  <= bus.an;
            r_an_s2  <= r_an_s1;
            r_an_q   <= r_an_s2;
        end
    end

    assign w_onehot       = is_onehot_low(r_an_s2);
    assign w_prev_onehot  = is_onehot_low(r_an_q);
    assign w_illegal      = !w_onehot && (r_an_s2 != 4'b1111);
    assign w_prev_illegal = !w_prev_onehot && (r_an_q != 4'b1111);
    assign w_same         = (r_seg_s2 == r_seg_q) && (r_an_s2 == r_an_q);

    always_comb begin
        w_dec_hit = 1'b1;
        w_dec_nib = 4'h0;
        case (r_seg_s2)
            7'b0000001: w_dec_nib = 4'h0;
            7'b1001111: w_dec_nib = 4'h1;
            7'b0010010: w_dec_nib = 4'h2;
            7'b0000110: w_dec_nib = 4'h3;
            7'b1001100: w_dec_nib = 4'h4;
            7'b0100100: w_dec_nib = 4'h5;
            7'b0100000: w_dec_nib = 4'h6;
            7'b0001111: w_dec_nib = 4'h7;
            7'b0000000: w_dec_nib = 4'h8;
            7'b0001100: w_dec_nib = 4'h9;
            7'b0001000: w_dec_nib = 4'hA;
            7'b1100000: w_dec_nib = 4'hB;
            7'b0110001: w_dec_nib = 4'hC;
            7'b1000010: w_dec_nib = 4'hD;
            7'b0110000: w_dec_nib = 4'hE;
            7'b0111000: w_dec_nib = 4'hF;
            default:    w_dec_hit = 1'b0;
        endcase
    end

    assign w_dec_blank = (r_seg_s2 == 7'b1111111);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A dwell is one unbroken run of identical an/seg; HELD blocks a second capture
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cnt_new   = 8'd1;
        w_capture   = 1'b0;
        if (!w_onehot) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = 8'd0;
        end else if (!((r_state == c_st_held) && w_same)) begin
            if ((r_state == c_st_track) && w_same) begin
                w_cnt_new = r_cnt + 8'd1;
            end
            w_cnt_nxt = w_cnt_new;
            if (w_cnt_new == c_stable) begin
                w_capture   = 1'b1;
                w_state_nxt = c_st_held;
            end else begin
                w_state_nxt = c_st_track;
            end
        end
    end

    assign w_cap_bits = w_capture ? ~r_an_s2 : 4'b0000;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh_val   <= 16'h0000;
            r_sh_valid <= 4'b0000;
            r_sh_blank <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_cap_bits[i]) begin
                    r_sh_val[4*i +: 4] <= w_dec_nib;
                    r_sh_valid[i]      <= w_dec_hit;
                    r_sh_blank[i]      <= w_dec_blank;
                end
            end
        end
    end

    // Frame publishes one cycle after the mask fills; a capture landing in that
    // same cycle seeds the next frame's mask.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask       <= 4'b0000;
            r_value      <= 16'h0000;
            r_valid      <= 4'b0000;
            r_blank      <= 4'b0000;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_mask == 4'b1111) begin
                r_value      <= r_sh_val;
                r_valid      <= r_sh_valid;
                r_blank      <= r_sh_blank;
                r_frame_done <= 1'b1;
                r_mask       <= w_cap_bits;
            end else begin
                r_mask       <= r_mask | w_cap_bits;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bad_pat <= 1'b0;
            r_an_err  <= 1'b0;
            r_idle    <= 24'd0;
        end else begin
            r_bad_pat <= w_capture && !w_dec_hit && !w_dec_blank;
            r_an_err  <= w_illegal && !w_prev_illegal;
            if (w_capture) begin
                r_idle <= 24'd0;
            end else if (r_idle != c_timeout) begin
                r_idle <= r_idle + 24'd1;
            end
        end
    end

    assign bus.value      = r_value;
    assign bus.valid      = r_valid;
    assign bus.blank      = r_blank;
    assign bus.frame_done = r_frame_done;
    assign bus.bad_pat    = r_bad_pat;
    assign bus.an_err     = r_an_err;
    assign bus.stale      = (r_idle == c_timeout);

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_decoder
// Purpose  : Directed self-checking bench for seg7_scan_decoder.
// Revision : 1.0
// ============================================================================
module tb_seg7_scan_decoder;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   n_fd;
    int   n_bp;
    int   n_ae;

    seg7_scan_decoder_if bus_if ();

    seg7_scan_decoder #(
        .STABLE_CYCLES(4),
        .TIMEOUT      (40)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus_if.frame_done === 1'b1) n_fd++;
        if (bus_if.bad_pat === 1'b1)    n_bp++;
        if (bus_if.an_err === 1'b1)     n_ae++;
    end

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0001100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input logic [3:0] a, input logic [6:0] s, input int n);
        bus_if.an  = a;
        bus_if.seg = s;
        step(n);
    endtask

    task automatic digit(input int d, input logic [3:0] nib, input int n);
        logic [3:0] sel;
        sel = 4'b0001 << d;
        show(~sel, seg_of(nib), n);
    endtask

    task automatic do_reset();
        bus_if.an  = 4'b1111;
        bus_if.seg = 7'b1111111;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus_if.an  = 4'b0011;
        bus_if.seg = 7'b1010101;
        step(2);
        n_checks++; if (bus_if.value !== 16'h0000) begin n_errors++; $display("FAIL reset_value: got %h expected 0000", bus_if.value); end
        n_checks++; if (bus_if.valid !== 4'b0000) begin n_errors++; $display("FAIL reset_valid: got %b expected 0000", bus_if.valid); end
        n_checks++; if (bus_if.blank !== 4'b0000) begin n_errors++; $display("FAIL reset_blank: got %b expected 0000", bus_if.blank); end
        n_checks++; if (bus_if.frame_done !== 1'b0) begin n_errors++; $display("FAIL reset_frame_done: got %b expected 0", bus_if.frame_done); end
        n_checks++; if (bus_if.bad_pat !== 1'b0) begin n_errors++; $display("FAIL reset_bad_pat: got %b expected 0", bus_if.bad_pat); end
        n_checks++; if (bus_if.an_err !== 1'b0) begin n_errors++; $display("FAIL reset_an_err: got %b expected 0", bus_if.an_err); end
        n_checks++; if (bus_if.stale !== 1'b0) begin n_errors++; $display("FAIL reset_stale: got %b expected 0", bus_if.stale); end
        bus_if.an  = 4'b1111;
        bus_if.seg = 7'b1111111;
        rst = 1'b0;
        step(3);
        n_checks++; if (bus_if.value !== 16'h0000) begin n_errors++; $display("FAIL post_reset_value: got %h expected 0000", bus_if.value); end
    endtask

    task automatic test_scan_frame();
        int fd0, bp0;
        do_reset();
        fd0 = n_fd; bp0 = n_bp;
        digit(0, 4'h3, 10);
        digit(1, 4'hA, 10);
        digit(2, 4'hF, 10);
        n_checks++; if (bus_if.value !== 16'h0000) begin n_errors++; $display("FAIL scan_value_hold: got %h expected 0000", bus_if.value); end
        digit(3, 4'h0, 10);
        show(4'b1111, 7'b1111111, 3);
        n_checks++; if (n_fd - fd0 !== 1) begin n_errors++; $display("FAIL scan_frames: got %0d expected 1", n_fd - fd0); end
        n_checks++; if (bus_if.value !== 16'h0FA3) begin n_errors++; $display("FAIL scan_value: got %h expected 0fa3", bus_if.value); end
        n_checks++; if (bus_if.valid !== 4'b1111) begin n_errors++; $display("FAIL scan_valid: got %b expected 1111", bus_if.valid); end
        n_checks++; if (bus_if.blank !== 4'b0000) begin n_errors++; $display("FAIL scan_blank: got %b expected 0000", bus_if.blank); end
        n_checks++; if (n_bp - bp0 !== 0) begin n_errors++; $display("FAIL scan_bad_pat: got %0d expected 0", n_bp - bp0); end
    endtask

    task automatic test_short_dwell_stale();
        int fd0;
        do_reset();
        fd0 = n_fd;
        for (int i = 0; i < 13; i++) digit(i % 4, 4'h8, 3);
        n_checks++; if (bus_if.stale !== 1'b0) begin n_errors++; $display("FAIL stale_early: got %b expected 0", bus_if.stale); end
        show(4'b1111, 7'b1111111, 1);
        n_checks++; if (bus_if.stale !== 1'b1) begin n_errors++; $display("FAIL stale_at_timeout: got %b expected 1", bus_if.stale); end
        n_checks++; if (n_fd - fd0 !== 0) begin n_errors++; $display("FAIL short_dwell_frames: got %0d expected 0", n_fd - fd0); end
        n_checks++; if (bus_if.value !== 16'h0000) begin n_errors++; $display("FAIL short_dwell_value: got %h expected 0000", bus_if.value); end
        digit(0, 4'h1, 5);
        n_checks++; if (bus_if.stale !== 1'b1) begin n_errors++; $display("FAIL stale_before_capture: got %b expected 1", bus_if.stale); end
        step(1);
        n_checks++; if (bus_if.stale !== 1'b0) begin n_errors++; $display("FAIL stale_after_capture: got %b expected 0", bus_if.stale); end
    endtask

    task automatic test_blank_badpat();
        int fd0, bp0;
        do_reset();
        fd0 = n_fd; bp0 = n_bp;
        digit(0, 4'h1, 10);
        show(4'b1101, 7'b1010101, 10);
        show(4'b1011, 7'b1111111, 10);
        digit(3, 4'h8, 10);
        show(4'b1111, 7'b1111111, 3);
        n_checks++; if (n_fd - fd0 !== 1) begin n_errors++; $display("FAIL blank_frames: got %0d expected 1", n_fd - fd0); end
        n_checks++; if (bus_if.value !== 16'h8001) begin n_errors++; $display("FAIL blank_value: got %h expected 8001", bus_if.value); end
        n_checks++; if (bus_if.valid !== 4'b1001) begin n_errors++; $display("FAIL blank_valid: got %b expected 1001", bus_if.valid); end
        n_checks++; if (bus_if.blank !== 4'b0100) begin n_errors++; $display("FAIL blank_blank: got %b expected 0100", bus_if.blank); end
        n_checks++; if (n_bp - bp0 !== 1) begin n_errors++; $display("FAIL bad_pat_count: got %0d expected 1", n_bp - bp0); end
    endtask

    task automatic test_an_err();
        int fd0, ae0;
        do_reset();
        fd0 = n_fd; ae0 = n_ae;
        digit(0, 4'h5, 10);
        digit(1, 4'hC, 10);
        show(4'b1100, seg_of(4'h8), 5);
        digit(2, 4'h7, 10);
        digit(3, 4'hE, 10);
        show(4'b1111, 7'b1111111, 3);
        n_checks++; if (n_ae - ae0 !== 1) begin n_errors++; $display("FAIL an_err_count: got %0d expected 1", n_ae - ae0); end
        n_checks++; if (n_fd - fd0 !== 1) begin n_errors++; $display("FAIL an_err_frames: got %0d expected 1", n_fd - fd0); end
        n_checks++; if (bus_if.value !== 16'hE7C5) begin n_errors++; $display("FAIL an_err_value: got %h expected e7c5", bus_if.value); end
        n_checks++; if (bus_if.valid !== 4'b1111) begin n_errors++; $display("FAIL an_err_valid: got %b expected 1111", bus_if.valid); end
    endtask

    task automatic test_glitch();
        do_reset();
        digit(0, 4'h2, 10);
        digit(1, 4'h4, 10);
        digit(2, 4'h6, 10);
        digit(3, 4'h9, 2);
        digit(3, 4'hB, 6);
        n_checks++; if (bus_if.frame_done !== 1'b0) begin n_errors++; $display("FAIL glitch_early_frame: got %b expected 0", bus_if.frame_done); end
        n_checks++; if (bus_if.value !== 16'h0000) begin n_errors++; $display("FAIL glitch_early_value: got %h expected 0000", bus_if.value); end
        step(1);
        n_checks++; if (bus_if.frame_done !== 1'b1) begin n_errors++; $display("FAIL glitch_frame_timing: got %b expected 1", bus_if.frame_done); end
        n_checks++; if (bus_if.value !== 16'hB642) begin n_errors++; $display("FAIL glitch_value: got %h expected b642", bus_if.value); end
        step(1);
        n_checks++; if (bus_if.frame_done !== 1'b0) begin n_errors++; $display("FAIL frame_done_width: got %b expected 0", bus_if.frame_done); end
    endtask

    task automatic test_back_to_back();
        int fd0;
        do_reset();
        fd0 = n_fd;
        digit(0, 4'h1, 10);
        digit(0, 4'h2, 10);
        digit(1, 4'h3, 10);
        digit(2, 4'h4, 10);
        digit(3, 4'h5, 10);
        n_checks++; if (bus_if.value !== 16'h5432) begin n_errors++; $display("FAIL recapture_value: got %h expected 5432", bus_if.value); end
        digit(0, 4'h6, 10);
        digit(1, 4'h7, 10);
        digit(2, 4'h8, 10);
        digit(3, 4'h9, 10);
        show(4'b1111, 7'b1111111, 3);
        n_checks++; if (n_fd - fd0 !== 2) begin n_errors++; $display("FAIL b2b_frames: got %0d expected 2", n_fd - fd0); end
        n_checks++; if (bus_if.value !== 16'h9876) begin n_errors++; $display("FAIL b2b_value: got %h expected 9876", bus_if.value); end
    endtask

    task automatic test_reset_midframe();
        int fd0;
        do_reset();
        digit(0, 4'h1, 10);
        digit(1, 4'h2, 10);
        digit(2, 4'h3, 10);
        digit(3, 4'h4, 10);
        n_checks++; if (bus_if.value !== 16'h4321) begin n_errors++; $display("FAIL pre_reset_value: got %h expected 4321", bus_if.value); end
        digit(0, 4'h5, 10);
        digit(1, 4'h6, 10);
        digit(2, 4'h7, 10);
        bus_if.an  = 4'b1111;
        bus_if.seg = 7'b1111111;
        rst = 1'b1;
        step(1);
        n_checks++; if (bus_if.value !== 16'h0000) begin n_errors++; $display("FAIL midreset_value: got %h expected 0000", bus_if.value); end
        n_checks++; if (bus_if.valid !== 4'b0000) begin n_errors++; $display("FAIL midreset_valid: got %b expected 0000", bus_if.valid); end
        rst = 1'b0;
        fd0 = n_fd;
        digit(3, 4'hD, 10);
        digit(0, 4'h8, 10);
        digit(1, 4'h9, 10);
        n_checks++; if (n_fd - fd0 !== 0) begin n_errors++; $display("FAIL midreset_partial: got %0d expected 0", n_fd - fd0); end
        digit(2, 4'hA, 10);
        show(4'b1111, 7'b1111111, 3);
        n_checks++; if (n_fd - fd0 !== 1) begin n_errors++; $display("FAIL midreset_frames: got %0d expected 1", n_fd - fd0); end
        n_checks++; if (bus_if.value !== 16'hDA98) begin n_errors++; $display("FAIL midreset_new_value: got %h expected da98", bus_if.value); end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_fd = 0;
        n_bp = 0;
        n_ae = 0;
        rst = 1'b1;
        bus_if.an  = 4'b1111;
        bus_if.seg = 7'b1111111;
        test_reset();
        test_scan_frame();
        test_short_dwell_stale();
        test_blank_badpat();
        test_an_err();
        test_glitch();
        test_back_to_back();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg7_scan_decoder.md
SEG7_SCAN_DECODER -- requirements
Module: seg7_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4, consecutive identical samples required before a digit is captured (range 1-255).
REQ-002 Parameter TIMEOUT, default 1000000, idle cycles without any capture before stale asserts (range 1 to 2^24-1).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 seg  input  7  segment lines, active-low (0 = lit), seg[6]=a, seg[5]=b, ..., seg[0]=g.
REQ-006 an  input  4  digit anode selects, active-low, one-hot-low when a digit is driven.
REQ-007 value  output  16  last complete frame, 4 bits per digit, digit i in value[4i+3:4i].
REQ-008 valid  output  4  per-digit flag: decoded nibble in value is a legal hex pattern.
REQ-009 blank  output  4  per-digit flag: digit was 7'b1111111 (all off).
REQ-010 frame_done  output  1  one-cycle pulse when value/valid/blank update.
REQ-011 bad_pat  output  1  one-cycle pulse on capture of an unrecognised non-blank pattern.
REQ-012 an_err  output  1  one-cycle pulse on first cycle of an illegal anode code (more than one bit low).
REQ-013 stale  output  1  level; no capture for TIMEOUT cycles.

Function
REQ-014 Decode table (seg -> nibble): 0000001->0, 1001111->1, 0010010->2, 0000110->3, 1001100->4, 0100100->5, 0100000->6, 0001111->7, 0000000->8, 0001100->9, 0001000->A, 1100000->B, 0110001->C, 1000010->D, 0110000->E, 0111000->F.
REQ-015 Inputs seg and an registered through a two-flop synchroniser; all further logic uses synchronised values (2-cycle input latency).
REQ-016 FSM states IDLE, TRACK, HELD; reset state IDLE.
REQ-017 IDLE: an == 4'b1111; stability counter cleared; one-hot-low an -> TRACK with counter = 1.
REQ-018 TRACK: each cycle with an and seg equal to previous cycle increments counter; any change in seg or an restarts counter at 1 (new one-hot-low an) or goes to IDLE (an all high).
REQ-019 TRACK: counter reaching STABLE_CYCLES captures the digit into a shadow slot, sets its captured-mask bit, -> HELD; capture cycle counts as cycle STABLE_CYCLES.
REQ-020 HELD: no further capture while an and seg unchanged; change -> same handling as REQ-018; guarantees exactly one capture per dwell.
REQ-021 Capture: matching pattern -> shadow nibble = table value, valid=1, blank=0; 1111111 -> nibble 0, valid=0, blank=1; otherwise nibble 0, valid=0, blank=0, bad_pat pulses same cycle.
REQ-022 Re-capture of a digit before frame completion overwrites its shadow slot; no error.
REQ-023 Cycle after the capture that makes captured-mask 4'b1111: value/valid/blank load from shadow, frame_done pulses, mask clears; captures in that cycle count toward the next frame.
REQ-024 Illegal an (two or more bits low): -> IDLE-equivalent handling, counter cleared, no capture, an_err pulses once per contiguous illegal run.
REQ-025 Idle counter increments every cycle, clears on capture, saturates at TIMEOUT; stale = (idle counter == TIMEOUT); stale deasserts the cycle after a capture.
REQ-026 Outputs value, valid, blank registered; change only per REQ-023 or reset.

Reset
REQ-027 rst high: state IDLE, counters 0, mask 0, shadow 0, synchroniser flops seg=7'b1111111 and an=4'b1111, value=16'h0000, valid=4'b0000, blank=4'b0000, frame_done/bad_pat/an_err=0, stale=0.
REQ-028 rst asserted mid-dwell or mid-frame discards partial frame; first frame_done after release needs four fresh captures.

Verification
REQ-029 Scan an=1110/1101/1011/0111 with seg for 3,A,F,0, dwell 10 cycles each, STABLE_CYCLES=4 -> one frame_done, value=16'h0FA3, valid=4'b1111, blank=0.
REQ-030 Dwell of 3 cycles per digit with STABLE_CYCLES=4 -> no capture, no frame_done, stale after TIMEOUT cycles.
REQ-031 Digit 2 drives 1111111, digit 1 drives 1010101 -> frame_done with blank=4'b0100, valid=4'b1001, one bad_pat pulse.
REQ-032 an=1100 for 5 cycles mid-scan -> single an_err pulse, no capture; scan resumes and completes normally.
REQ-033 seg glitches on cycle 3 of a dwell -> counter restarts, capture occurs 4 cycles after glitch with post-glitch value.
REQ-034 rst pulsed after three digits captured -> all outputs zero; next frame_done only after four new captures.
